seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the board's hex-to-7-segment display path.
- Samples a multiplexed, active-low 7-segment bus (segment lines plus per-digit select) and decodes each stable glyph back to a 4-bit hex nibble.
- Assembles one nibble per digit into a full frame word and hands it out over a valid/ready interface.
- Used for loopback self-test of the display driver and for capturing display content in simulation.

Parameters:
- NDIG, 8, number of multiplexed digits; frame word width is 4*NDIG.
- STABLE_CYC, 4, consecutive identical cycles required before a sample is accepted (range 1..255).
- TIMEOUT_CYC, 4096, idle cycles after which a partial frame is discarded (range 2..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- seg_n  in  7  segment lines, active-low; bit0=a … bit6=g.
- dig_sel_n  in  NDIG  digit enables, active-low, expected one-hot-low.
- out_data  out  4*NDIG  captured frame; digit i occupies bits [4i+3:4i].
- out_blank  out  NDIG  per-digit flag: glyph was all-off.
- out_err  out  NDIG  per-digit flag: glyph not in the decode table.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky: a completed frame was dropped; cleared only by reset.
- timeout_pulse  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (async assert, sync release): all outputs 0; capture mask, stability counter and timeout counter 0; state SETTLE.
- Input registration: seg_n and dig_sel_n are registered once. All behaviour below uses the registered values, so an input change affects state one cycle later.
- Selection validity:
  - Valid only when exactly one bit of dig_sel_n is 0.
  - Zero or multiple selected: stability counter clears, no capture, state returns to SETTLE.
- State machine:
  - SETTLE: counts while {sel, seg} equals the previous cycle.
    - Any change reloads the counter to 1.
    - When the counter reaches STABLE_CYC, go to CAPTURE.
  - CAPTURE: single cycle.
    - Decode seg into the slot of the selected digit; set that mask bit.
    - Go to LOCKED.
  - LOCKED: holds while {sel, seg} is unchanged, so the same glyph is never re-captured.
    - On any change, go to SETTLE with the counter at 1.
- Decode table (active-high pattern gfedcba → nibble):
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
  - 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9
  - 1110111→A, 1111100→B, 0111001→C, 1011110→D, 1111001→E, 1110001→F
  - 0000000 → nibble 0, blank=1, err=0.
  - Any other pattern → nibble 0, err=1, blank=0.
- Re-capture: a digit captured again before the frame completes overwrites its slot and flags; the mask is unchanged.
- Frame complete: the cycle the mask becomes all-ones.
  - If !out_valid, or out_valid && out_ready in that same cycle: load out_data/out_blank/out_err, set out_valid next cycle, clear mask.
  - Otherwise: set overrun, clear mask, leave the held output untouched.
- Output handshake: out_valid stays high and its data stays stable until out_valid && out_ready; it then drops the following cycle unless a new frame loads in that same cycle.
- Timeout:
  - Counter increments each cycle while the mask is nonzero and no CAPTURE occurs; CAPTURE resets it to 0.
  - Reaching TIMEOUT_CYC clears the mask, resets the counter, and pulses timeout_pulse for one cycle. out_valid is unaffected.
- Reset mid-frame: partial frame and held output are lost; out_valid=0 immediately.

Decomposition:
- Package seg7_pkg:
  - 16-entry glyph constant table.
  - BLANK_GLYPH constant.
  - State enum {SETTLE, CAPTURE, LOCKED}.
  - Function onehot_low_index returning the index plus a valid bit.
- Sub-module seg7_glyph_decode: purely combinational, 7-bit active-high pattern → {nibble, blank, err}. Reused by the display-driver self-check.

Test Plan:
- NDIG=8, STABLE_CYC=4. Scan digits 0..7 showing glyphs 1,2,3,4,5,6,7,8, each held 10 cycles, out_ready=1 → one out_valid pulse with out_data=0x87654321, out_blank=0, out_err=0.
- Digit 3 driven with glyph toggling every 3 cycles (below STABLE_CYC) → no capture for digit 3, no out_valid. Then hold glyph 0x0000110 for 4 cycles → digit 3 captured as 1.
- Digit 5 shows 1111100 and digit 2 shows 1111101 → nibbles B and 6. Digit 0 shows 1000000 → err bit 0 set, nibble 0. Digit 7 all-off → blank bit 7 set.
- out_ready=0, two full frames scanned → first frame held unchanged, overrun=1 after the second completes. Then out_ready=1 → out_valid drops next cycle.
- TIMEOUT_CYC=64: capture digits 0..3, then dig_sel_n=all-ones for 64 cycles → timeout_pulse once, mask cleared. Next full scan yields a fresh frame.
- Assert rst_n=0 mid-scan with out_valid=1 → all outputs 0 asynchronously. After release, a full scan is needed before out_valid rises again.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture path.
// Contents:
//   GLYPH_TABLE       - active-high gfedcba pattern for each hex nibble 0..F
//   BLANK_GLYPH       - all-segments-off pattern
//   state_t           - capture state machine encoding
//   sel_index_t       - decoded digit select {valid, index}
//   onehot_low_index  - finds the single low bit of an active-low select bus
package seg7_pkg;

  // Widest select bus the index helper handles; callers pad unused bits with 1.
  localparam int MAX_DIG = 32;

  localparam logic [6:0] BLANK_GLYPH = 7'b0000000;

  // Index = nibble value, entry = active-high segment pattern (bit0=a .. bit6=g).
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef enum logic [1:0] {
    SETTLE,
    CAPTURE,
    LOCKED
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] index;
  } sel_index_t;

  // valid is set only when exactly one bit of sel_n is low.
  function automatic sel_index_t onehot_low_index(input logic [MAX_DIG-1:0] sel_n);
    sel_index_t  r;
    int unsigned zeros;
    r     = '0;
    zeros = 0;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (!sel_n[i]) begin
        zeros++;
        r.index = 5'(i);
      end
    end
    r.valid = (zeros == 1);
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph decoder.
// Ports:
//   pattern - active-high segment pattern, bit0=a .. bit6=g
//   nibble  - decoded hex value (0 when blank or unrecognised)
//   blank   - pattern had every segment off
//   err     - pattern is neither a hex glyph nor blank
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a value before any branch so no path can leave
    // one unassigned, which would otherwise infer a latch.
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b1;
    if (pattern == BLANK_GLYPH) begin
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pattern == GLYPH_TABLE[i]) begin
          nibble = 4'(i);
          err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed active-low 7-segment bus, decodes each stable glyph
// back to a hex nibble and assembles one nibble per digit into a frame word
// handed out over a valid/ready interface.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   seg_n         - segment lines, active-low, bit0=a .. bit6=g
//   dig_sel_n     - per-digit enables, active-low, one-hot-low when valid
//   out_data      - captured frame, digit i in bits [4i+3:4i]
//   out_blank     - per-digit all-off flag
//   out_err       - per-digit unrecognised-glyph flag
//   out_valid     - frame available; held until out_valid && out_ready
//   out_ready     - consumer accepts the frame
//   overrun       - sticky: a completed frame was dropped (reset clears)
//   timeout_pulse - one-cycle pulse when a partial frame is discarded
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIG        = 8,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_sel_n,
  output logic [4*NDIG-1:0] out_data,
  output logic [NDIG-1:0]   out_blank,
  output logic [NDIG-1:0]   out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              timeout_pulse
);

  // Input stage (_q) and its one-cycle-older copy (_d) used for change detect.
  logic [6:0]      seg_q, seg_d;
  logic [NDIG-1:0] sel_q, sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (!rst_n) begin
      seg_q <= '1;
      seg_d <= '1;
      sel_q <= '1;
      sel_d <= '1;
    end else begin
      seg_q <= seg_n;
      seg_d <= seg_q;
      sel_q <= dig_sel_n;
      sel_d <= sel_q;
    end
  end

  logic [MAX_DIG-1:0] sel_pad;
  sel_index_t         sel_now;
  logic               changed;

  always_comb begin
    sel_pad             = '1;
    sel_pad[NDIG-1:0]   = sel_q;
  end

  assign sel_now = onehot_low_index(sel_pad);
  assign changed = (sel_q != sel_d) || (seg_q != seg_d);

  // Stability state machine.
  state_t     state;
  logic [7:0] stab_cnt;
  logic [7:0] stab_next;
  logic [4:0] cap_idx;
  logic       capture;

  assign stab_next = changed ? 8'd1 : stab_cnt + 8'd1;
  assign capture   = (state == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SETTLE;
      stab_cnt <= '0;
      cap_idx  <= '0;
    end else if (!sel_now.valid) begin
      state    <= SETTLE;
      stab_cnt <= '0;
    end else begin
      case (state)
        SETTLE: begin
          stab_cnt <= stab_next;
          if (stab_next >= 8'(STABLE_CYC)) begin
            state   <= CAPTURE;
            cap_idx <= sel_now.index;
          end
        end
        // The glyph written in CAPTURE is the delayed copy, i.e. the value that
        // was stable; a change arriving in this very cycle restarts settling.
        CAPTURE: begin
          if (changed) begin
            state    <= SETTLE;
            stab_cnt <= 8'd1;
          end else begin
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (changed) begin
            state    <= SETTLE;
            stab_cnt <= 8'd1;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_err;

  seg7_glyph_decode u_decode (
    .pattern (~seg_d),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  // Frame assembly.
  logic [NDIG-1:0]   mask, mask_next, cap_bit;
  logic [4*NDIG-1:0] frame_data, data_next;
  logic [NDIG-1:0]   frame_blank, blank_next;
  logic [NDIG-1:0]   frame_err, err_next;
  logic              frame_done;
  logic [15:0]       to_cnt, to_inc;
  logic              to_hit;

  always_comb begin
    cap_bit    = '0;
    for (int i = 0; i < NDIG; i++) begin
      cap_bit[i] = capture && (cap_idx == 5'(i));
    end
    mask_next  = mask | cap_bit;
    data_next  = frame_data;
    blank_next = frame_blank;
    err_next   = frame_err;
    for (int i = 0; i < NDIG; i++) begin
      if (cap_bit[i]) begin
        data_next[4*i +: 4] = dec_nibble;
        blank_next[i]       = dec_blank;
        err_next[i]         = dec_err;
      end
    end
  end

  assign frame_done = capture && (&mask_next);
  assign to_inc     = to_cnt + 16'd1;
  assign to_hit     = (mask != '0) && !capture && (to_inc == 16'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the slot buffer is reset along with the control state; it is only
    // NDIG entries wide, and resetting it keeps out_data deterministic.
    if (!rst_n) begin
      mask          <= '0;
      frame_data    <= '0;
      frame_blank   <= '0;
      frame_err     <= '0;
      to_cnt        <= '0;
      timeout_pulse <= 1'b0;
      out_data      <= '0;
      out_blank     <= '0;
      out_err       <= '0;
      out_valid     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      frame_data    <= data_next;
      frame_blank   <= blank_next;
      frame_err     <= err_next;

      if (capture || to_hit) begin
        to_cnt <= '0;
      end else if (mask != '0) begin
        to_cnt <= to_inc;
      end

      if (to_hit) begin
        mask          <= '0;
        timeout_pulse <= 1'b1;
      end else if (frame_done) begin
        mask <= '0;
      end else begin
        mask <= mask_next;
      end

      // A completed frame loads only if the output slot is free or being
      // drained this same cycle; otherwise it is dropped and flagged.
      if (frame_done && (!out_valid || out_ready)) begin
        out_data  <= data_next;
        out_blank <= blank_next;
        out_err   <= err_next;
        out_valid <= 1'b1;
      end else begin
        if (frame_done) begin
          overrun <= 1'b1;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  localparam int NDIG    = 8;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic              clk;
  logic              rst_n;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   dig_sel_n;
  logic [4*NDIG-1:0] out_data;
  logic [NDIG-1:0]   out_blank;
  logic [NDIG-1:0]   out_err;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic              timeout_pulse;

  seg7_scan_capture #(
    .NDIG        (NDIG),
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_n         (seg_n),
    .dig_sel_n     (dig_sel_n),
    .out_data      (out_data),
    .out_blank     (out_blank),
    .out_err       (out_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .timeout_pulse (timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  err;
  } frame_t;

  frame_t      exp_q[$];
  logic [31:0] m_data    = '0;
  logic [7:0]  m_blank   = '0;
  logic [7:0]  m_err     = '0;
  logic [7:0]  m_mask    = '0;
  logic        m_busy    = 1'b0;
  logic        m_overrun = 1'b0;
  int          m_pulses  = 0;

  int          act_pulses = 0;
  int          n_frames   = 0;
  logic [31:0] last_data  = '0;
  logic [7:0]  last_blank = '0;
  logic [7:0]  last_err   = '0;

  // {err, blank, nibble} straight from the glyph table.
  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    case (p)
      7'b0111111: return 6'h00;
      7'b0000110: return 6'h01;
      7'b1011011: return 6'h02;
      7'b1001111: return 6'h03;
      7'b1100110: return 6'h04;
      7'b1101101: return 6'h05;
      7'b1111101: return 6'h06;
      7'b0000111: return 6'h07;
      7'b1111111: return 6'h08;
      7'b1101111: return 6'h09;
      7'b1110111: return 6'h0A;
      7'b1111100: return 6'h0B;
      7'b0111001: return 6'h0C;
      7'b1011110: return 6'h0D;
      7'b1111001: return 6'h0E;
      7'b1110001: return 6'h0F;
      7'b0000000: return 6'h10;
      default:    return 6'h20;
    endcase
  endfunction

  // A digit held for at least STABLE cycles is captured once.
  task automatic model_capture(input int dig, input logic [6:0] pat, input int hold);
    logic [5:0] d;
    frame_t     f;
    if (hold >= STABLE) begin
      d = ref_decode(pat);
      m_data[4*dig +: 4] = d[3:0];
      m_blank[dig]       = d[4];
      m_err[dig]         = d[5];
      m_mask[dig]        = 1'b1;
      if (m_mask == 8'hFF) begin
        m_mask = '0;
        if (m_busy && !out_ready) begin
          m_overrun = 1'b1;
        end else begin
          f.data  = m_data;
          f.blank = m_blank;
          f.err   = m_err;
          exp_q.push_back(f);
          m_busy = 1'b1;
        end
      end
    end
  endtask

  task automatic show(input int dig, input logic [6:0] pat, input int hold);
    dig_sel_n = ~(8'd1 << dig);
    seg_n     = ~pat;
    model_capture(dig, pat, hold);
    repeat (hold) @(negedge clk);
  endtask

  task automatic scan8(input logic [31:0] nibs);
    for (int i = 0; i < 8; i++) show(i, GLYPH[nibs[4*i +: 4]], 10);
  endtask

  task automatic idle(input int n);
    dig_sel_n = '1;
    seg_n     = '1;
    if (n >= TIMEOUT && m_mask != '0) begin
      m_pulses++;
      m_mask = '0;
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Compare process: every cycle the output is valid it must match the
  // oldest expected frame; a handshake retires that frame.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (timeout_pulse) act_pulses++;
        if (out_valid) begin
          check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_blank", 32'(out_blank), 32'(exp_q[0].blank));
            check("out_err", 32'(out_err), 32'(exp_q[0].err));
            if (out_ready) begin
              last_data  = out_data;
              last_blank = out_blank;
              last_err   = out_err;
              n_frames++;
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int frames_before;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    dig_sel_n = '1;
    seg_n     = '1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    check("rst_flags", 32'({out_blank, out_err}), 32'd0);
    rst_n = 1'b1;

    // 1: plain scan of glyphs 1..8.
    @(negedge clk);
    out_ready = 1'b1;
    scan8(32'h87654321);
    wait_drain(20);
    check("t1_data", last_data, 32'h87654321);
    check("t1_blank", 32'(last_blank), 32'h0);
    check("t1_err", 32'(last_err), 32'h0);
    check("t1_frames", 32'(n_frames), 32'd1);
    check("t1_overrun", 32'(overrun), 32'd0);

    // 2: digit 3 toggling faster than STABLE, then held exactly STABLE cycles.
    for (int r = 0; r < 4; r++) begin
      show(3, GLYPH[2], 3);
      show(3, GLYPH[5], 3);
    end
    check("t2_no_valid", 32'(out_valid), 32'd0);
    show(3, 7'b0000110, 4);
    show(0, GLYPH[9], 10);
    show(1, GLYPH[10], 10);
    show(2, GLYPH[12], 10);
    show(4, GLYPH[13], 10);
    show(5, GLYPH[14], 10);
    show(6, GLYPH[15], 10);
    show(7, GLYPH[0], 10);
    wait_drain(20);
    check("t2_data", last_data, 32'h0FED1CA9);
    check("t2_frames", 32'(n_frames), 32'd2);

    // 3: B, 6, an illegal glyph and a blank digit.
    show(0, 7'b1000000, 10);
    show(1, GLYPH[7], 10);
    show(2, 7'b1111101, 10);
    show(3, GLYPH[10], 10);
    show(4, GLYPH[12], 10);
    show(5, 7'b1111100, 10);
    show(6, GLYPH[15], 10);
    show(7, 7'b0000000, 10);
    wait_drain(20);
    check("t3_data", last_data, 32'h0FBCA670);
    check("t3_blank", 32'(last_blank), 32'h80);
    check("t3_err", 32'(last_err), 32'h01);

    // 4: consumer stalled across two frames.
    @(negedge clk);
    out_ready = 1'b0;
    scan8(32'h76543210);
    check("t4_valid_held", 32'(out_valid), 32'd1);
    check("t4_first_data", out_data, 32'h76543210);
    check("t4_no_overrun_yet", 32'(overrun), 32'd0);
    scan8(32'hFEDCBA98);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_overrun_model", 32'(overrun), 32'(m_overrun));
    check("t4_still_first", out_data, 32'h76543210);
    check("t4_still_valid", 32'(out_valid), 32'd1);
    frames_before = n_frames;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    check("t4_valid_drop", 32'(out_valid), 32'd0);
    check("t4_popped", 32'(n_frames - frames_before), 32'd1);
    check("t4_popped_data", last_data, 32'h76543210);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: partial frame abandoned by timeout, then a fresh frame.
    for (int i = 0; i < 4; i++) show(i, GLYPH[9], 10);
    idle(TIMEOUT);
    check("t5_pulses_model", 32'(act_pulses), 32'(m_pulses));
    check("t5_pulses", 32'(act_pulses), 32'd1);
    check("t5_no_valid", 32'(out_valid), 32'd0);
    scan8(32'hCBA98765);
    wait_drain(20);
    check("t5_data", last_data, 32'hCBA98765);
    check("t5_pulses_after", 32'(act_pulses), 32'd1);

    // 6: reset while a frame is held and another is half scanned.
    @(negedge clk);
    out_ready = 1'b0;
    scan8(32'h89ABCDEF);
    check("t6_valid_before", 32'(out_valid), 32'd1);
    check("t6_overrun_sticky", 32'(overrun), 32'd1);
    show(0, GLYPH[1], 10);
    show(1, GLYPH[2], 10);
    dig_sel_n = ~8'h04;
    seg_n     = ~GLYPH[3];
    repeat (5) @(negedge clk);
    #2;
    rst_n     = 1'b0;
    dig_sel_n = '1;
    seg_n     = '1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    check("t6_rst_flags", 32'({out_blank, out_err}), 32'd0);
    exp_q.delete();
    m_busy    = 1'b0;
    m_mask    = '0;
    m_overrun = 1'b0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    frames_before = n_frames;
    for (int i = 4; i < 8; i++) show(i, GLYPH[i - 3], 10);
    check("t6_partial_no_valid", 32'(out_valid), 32'd0);
    check("t6_partial_no_frame", 32'(n_frames - frames_before), 32'd0);
    for (int i = 0; i < 4; i++) show(i, GLYPH[i + 5], 10);
    wait_drain(20);
    check("t6_data", last_data, 32'h43218765);
    check("t6_frames", 32'(n_frames - frames_before), 32'd1);
    check("t6_overrun_clear", 32'(overrun), 32'd0);

    repeat (5) @(negedge clk);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
